emmc_cmd_responder: RTL and testbench

EMMC_CMD_RESPONDER -- requirements
Module: emmc_cmd_responder

---
 rtl/emmc_cmd_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_emmc_cmd_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/emmc_cmd_responder.sv
// eMMC host command path: serialises a 48-bit command with CRC7 and collects the card response.
// Define EMMC_CMD_LONG_RESP_EN to add 136-bit (R2) response reception.
module emmc_cmd_responder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] command_i,
    input  logic [31:0] argument_i,
    input  logic        cmd_start,
    input  logic        cmd_int_rst,
    input  logic [1:0]  software_reset_i,
    output logic [31:0] response_0_o,
    output logic [31:0] response_1_o,
    output logic [31:0] response_2_o,
    output logic [31:0] response_3_o,
    output logic [4:0]  cmd_int_st,
    output logic        cc_int_puls,
    output logic        com_inh_cmd,
    output logic        cmd_o,
    output logic        cmd_oe,
    input  logic        cmd_i
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TX   = 3'd1;
    localparam logic [2:0] S_TURN = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_RX   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
`ifdef EMMC_CMD_LONG_RESP_EN
    localparam int unsigned RX_W = 136;
`else
    localparam int unsigned RX_W = 48;
`endif

    function automatic logic [6:0] crc7(input logic [39:0] bits);
        logic [6:0]  c;
        logic [39:0] m;
        logic        fb;
        c = '0;
        m = bits;
        for (int unsigned i = 0; i < 40; i++) begin
            fb = m[39] ^ c[6];
            m  = {m[38:0], 1'b0};
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    logic [2:0]      state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [9:0]      cmd_q, cmd_d;     // {index, index-check, crc-check, type}
    logic [47:0]     tx_sr_q, tx_sr_d;
    logic [RX_W-1:0] rx_sr_q, rx_sr_d;
    logic            tout_q, tout_d;
    logic            got_q, got_d;
    logic [4:0]      st_q, st_d;
    logic            pulse_q, pulse_d;
    logic [31:0]     resp0_q, resp0_d;
`ifdef EMMC_CMD_LONG_RESP_EN
    logic [95:0]     resp_hi_q, resp_hi_d;
`endif

    logic       rsp_none, rsp_long, rsp48, rsp_skip;
    logic [7:0] rx_last;
    logic       end_err, crc_err, idx_err;
    logic [4:0] done_st;
    logic       unused_ok;

    assign rsp_none = (cmd_q[1:0] == 2'b00);
    assign rsp_long = (cmd_q[1:0] == 2'b01);
    assign rsp48    = cmd_q[1];
`ifdef EMMC_CMD_LONG_RESP_EN
    assign rsp_skip = 1'b0;
    assign rx_last  = rsp_long ? 8'd134 : 8'd46;
`else
    assign rsp_skip = rsp_long;
    assign rx_last  = 8'd46;
`endif

    // rx_sr_q is cleared on the start bit, so bit RX_W-1.. holds the start bit after the final shift
    assign end_err = got_q && !rx_sr_q[0];
    assign crc_err = got_q && rsp48 && cmd_q[2] && (crc7(rx_sr_q[47:8]) != rx_sr_q[7:1]);
    assign idx_err = got_q && rsp48 && cmd_q[3] && (rx_sr_q[45:40] != cmd_q[9:4]);
    assign done_st = {idx_err, crc_err, tout_q,
                      end_err | crc_err | idx_err | tout_q | rsp_skip, 1'b1};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        tout_d    = tout_q;
        got_d     = got_q;
        st_d      = cmd_int_rst ? 5'b00000 : st_q;
        pulse_d   = 1'b0;
        resp0_d   = resp0_q;
`ifdef EMMC_CMD_LONG_RESP_EN
        resp_hi_d = resp_hi_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    cmd_d   = {command_i[13:8], command_i[4], command_i[3], command_i[1:0]};
                    tx_sr_d = {2'b01, command_i[13:8], argument_i,
                               crc7({2'b01, command_i[13:8], argument_i}), 1'b1};
                    tout_d  = 1'b0;
                    got_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_TX;
                end
            end
            S_TX: begin
                tx_sr_d = {tx_sr_q[46:0], 1'b1};
                cnt_d   = cnt_q + 8'd1;
                if (cnt_q == 8'd47) begin
                    cnt_d   = '0;
                    state_d = (rsp_none || rsp_skip) ? S_DONE : S_TURN;
                end
            end
            S_TURN: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'd1) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!cmd_i) begin
                    rx_sr_d = '0;
                    got_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RX;
                end else if (cnt_q == 8'd63) begin
                    tout_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RX: begin
                rx_sr_d = {rx_sr_q[RX_W-2:0], cmd_i};
                cnt_d   = cnt_q + 8'd1;
                if (cnt_q == rx_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                pulse_d = 1'b1;
                st_d    = st_d | done_st;
                if (got_q) begin
`ifdef EMMC_CMD_LONG_RESP_EN
                    if (rsp_long) begin
                        {resp_hi_d, resp0_d} = rx_sr_q[127:0];
                    end else begin
                        resp0_d = rx_sr_q[39:8];
                    end
`else
                    resp0_d = rx_sr_q[39:8];
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (software_reset_i[0]) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            st_d      = '0;
            pulse_d   = 1'b0;
            resp0_d   = resp0_q;
`ifdef EMMC_CMD_LONG_RESP_EN
            resp_hi_d = resp_hi_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cmd_q     <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            tout_q    <= 1'b0;
            got_q     <= 1'b0;
            st_q      <= '0;
            pulse_q   <= 1'b0;
            resp0_q   <= '0;
`ifdef EMMC_CMD_LONG_RESP_EN
            resp_hi_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            tout_q    <= tout_d;
            got_q     <= got_d;
            st_q      <= st_d;
            pulse_q   <= pulse_d;
            resp0_q   <= resp0_d;
`ifdef EMMC_CMD_LONG_RESP_EN
            resp_hi_q <= resp_hi_d;
`endif
        end
    end

    assign cmd_oe       = (state_q == S_TX);
    assign cmd_o        = cmd_oe ? tx_sr_q[47] : 1'b1;
    assign com_inh_cmd  = (state_q != S_IDLE);
    assign cc_int_puls  = pulse_q;
    assign cmd_int_st   = st_q;
    assign response_0_o = resp0_q;
`ifdef EMMC_CMD_LONG_RESP_EN
    assign {response_3_o, response_2_o, response_1_o} = resp_hi_q;
`else
    assign response_1_o = '0;
    assign response_2_o = '0;
    assign response_3_o = '0;
`endif

    assign unused_ok = ^{command_i[7:5], command_i[2], software_reset_i[1], rx_sr_q[RX_W-1]};

endmodule

// File: tb/tb_emmc_cmd_responder.sv
// Bench for emmc_cmd_responder: card model on cmd_i, reference frames and status built from the protocol rules.
module tb_emmc_cmd_responder;
`ifdef EMMC_CMD_LONG_RESP_EN
    localparam bit LONG = 1'b1;
`else
    localparam bit LONG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] command_i;
    logic [31:0] argument_i;
    logic        cmd_start;
    logic        cmd_int_rst;
    logic [1:0]  software_reset_i;
    logic [31:0] response_0_o, response_1_o, response_2_o, response_3_o;
    logic [4:0]  cmd_int_st;
    logic        cc_int_puls;
    logic        com_inh_cmd;
    logic        cmd_o;
    logic        cmd_oe;
    logic        cmd_i;

    emmc_cmd_responder dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .command_i        (command_i),
        .argument_i       (argument_i),
        .cmd_start        (cmd_start),
        .cmd_int_rst      (cmd_int_rst),
        .software_reset_i (software_reset_i),
        .response_0_o     (response_0_o),
        .response_1_o     (response_1_o),
        .response_2_o     (response_2_o),
        .response_3_o     (response_3_o),
        .cmd_int_st       (cmd_int_st),
        .cc_int_puls      (cc_int_puls),
        .com_inh_cmd      (com_inh_cmd),
        .cmd_o            (cmd_o),
        .cmd_oe           (cmd_oe),
        .cmd_i            (cmd_i)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_val(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // CRC7 as polynomial long division of msg * x^7 by x^7+x^3+1
    function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r = r ^ (47'h89 << (i - 7));
        return r[6:0];
    endfunction

    // Transaction description
    logic [5:0]   t_idx;
    logic [31:0]  t_arg;
    logic [1:0]   t_type;
    logic         t_ichk, t_cchk;
    int           t_n;          // WAIT cycles before start bit; -1 = card silent
    int           t_corrupt;    // 0 none, 1 CRC bit, 2 echoed index+1, 3 end bit 0
    logic [31:0]  t_status;
    logic [127:0] t_long;
    int           t_srst_cyc, t_start2_cyc, t_irst_cyc, t_rst_cyc;

    // Reference state
    logic [4:0]   m_st = '0;
    logic [127:0] m_resp = '0;
    logic [47:0]  r_tx;
    logic [4:0]   r_st;

    task automatic set_defaults();
        t_idx = 6'd0; t_arg = '0; t_type = 2'b10; t_ichk = 1'b0; t_cchk = 1'b0;
        t_n = -1; t_corrupt = 0; t_status = '0; t_long = '0;
        t_srst_cyc = -1; t_start2_cyc = -1; t_irst_cyc = -1; t_rst_cyc = -1;
    endtask

    task automatic run_cmd();
        logic [39:0]  msg, rbody;
        logic [47:0]  exp_tx, got_tx;
        logic [135:0] rf;
        logic [127:0] rsp_p;
        logic [5:0]   ridx;
        logic [6:0]   rcrc;
        logic [4:0]   new_st, st_p, exp_st;
        logic [13:0]  cmdw;
        logic         endb, silent, abort;
        int           L, exp_lat, lat, ntx, cstart;

        msg    = {2'b01, t_idx, t_arg};
        exp_tx = {msg, ref_crc7(msg), 1'b1};
        silent = (t_n < 0) || (t_n > 63);
        endb   = (t_corrupt != 3);
        rf = '0; L = 0;
        if (t_type[1]) begin
            ridx  = (t_corrupt == 2) ? t_idx + 6'd1 : t_idx;
            rbody = {2'b00, ridx, t_status};
            rcrc  = ref_crc7(rbody) ^ ((t_corrupt == 1) ? 7'h01 : 7'h00);
            rf[47:0] = {rbody, rcrc, endb};
            L = 48;
        end else if (t_type == 2'b01 && LONG) begin
            rf = {2'b00, 6'h3F, t_long[127:1], endb};
            L = 136;
        end

        new_st = 5'b00001;
        if (t_type == 2'b00) begin
            exp_lat = 50;
        end else if (t_type == 2'b01 && !LONG) begin
            exp_lat = 50;
            new_st |= 5'b00010;
        end else if (silent) begin
            exp_lat = 1 + 48 + 2 + 64 + 1;
            new_st |= 5'b00110;
        end else begin
            exp_lat = 1 + 48 + 2 + t_n + L + 1;
            if (!endb) new_st |= 5'b00010;
            if (L == 48 && t_cchk && t_corrupt == 1) new_st |= 5'b01010;
            if (L == 48 && t_ichk && t_corrupt == 2) new_st |= 5'b10010;
        end
        abort  = (t_srst_cyc >= 0) || (t_rst_cyc >= 0);
        cstart = 51 + t_n;
        cmdw   = {t_idx, 3'b000, t_ichk, t_cchk, 1'b0, t_type};

        lat = -1; ntx = 0; got_tx = '0; st_p = '0; rsp_p = '0;
        for (int cyc = 0; cyc < 270; cyc++) begin
            @(negedge clk);
            if (cmd_oe) begin
                got_tx = {got_tx[46:0], cmd_o};
                ntx++;
            end
            if (lat >= 0 && cyc == lat + 1) begin
                check_val("pulse_width", cc_int_puls, 1'b0);
                check_val("inh_after_done", com_inh_cmd, 1'b0);
                break;
            end
            if (cc_int_puls && lat < 0) begin
                lat   = cyc;
                st_p  = cmd_int_st;
                rsp_p = {response_3_o, response_2_o, response_1_o, response_0_o};
            end
            if (cyc == 1) check_val("inh_busy", com_inh_cmd, 1'b1);
            if (t_srst_cyc >= 0 && cyc == t_srst_cyc + 1)
                check_val("srst_idle", {cmd_oe, com_inh_cmd, cmd_int_st}, 7'd0);
            if (cyc == t_rst_cyc) begin
                rst_n = 1'b0;
                #1;
                check_val("reset_outs", {cmd_o, cmd_oe, com_inh_cmd, cc_int_puls, cmd_int_st,
                          response_3_o, response_2_o, response_1_o, response_0_o},
                          {1'b1, 136'd0});
                m_resp = '0;
            end
            if (t_rst_cyc >= 0 && cyc == t_rst_cyc + 1) rst_n = 1'b1;
            cmd_start        = (cyc == 0) || (cyc == t_start2_cyc);
            command_i        = (cyc == t_start2_cyc) ? (cmdw ^ 14'h0F00) : cmdw;
            argument_i       = t_arg;
            cmd_int_rst      = (cyc == t_irst_cyc);
            software_reset_i = (cyc == t_srst_cyc) ? 2'b01 : 2'b00;
            cmd_i = (L > 0 && !silent && cyc >= cstart && cyc < cstart + L)
                    ? rf[L - 1 - (cyc - cstart)] : 1'b1;
        end
        cmd_start = 1'b0; cmd_int_rst = 1'b0; software_reset_i = 2'b00; cmd_i = 1'b1; rst_n = 1'b1;

        r_tx = got_tx;
        r_st = st_p;
        if (abort) begin
            check_val("no_pulse_on_abort", lat, -1);
            m_st = '0;
        end else begin
            exp_st = ((t_irst_cyc >= 0 && t_irst_cyc <= exp_lat - 1) ? 5'b00000 : m_st) | new_st;
            m_st = exp_st;
            if (!silent && L == 48) m_resp[31:0] = rf[39:8];
            if (!silent && L == 136) m_resp = rf[127:0];
            check_val("latency", lat, exp_lat);
            check_val("tx_frame", got_tx, exp_tx);
            check_val("tx_bits", ntx, 48);
            check_val("status", st_p, exp_st);
            check_val("responses", rsp_p, m_resp);
        end
    endtask

    initial begin
        int sel;
        rst_n = 1'b0; command_i = '0; argument_i = '0; cmd_start = 1'b0;
        cmd_int_rst = 1'b0; software_reset_i = 2'b00; cmd_i = 1'b1;
        #1;
        check_val("por_outs", {cmd_o, cmd_oe, com_inh_cmd, cc_int_puls, cmd_int_st,
                  response_3_o, response_2_o, response_1_o, response_0_o}, {1'b1, 136'd0});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // CMD0, no response
        set_defaults(); t_type = 2'b00; t_irst_cyc = 0;
        run_cmd();
        check_val("cmd0_frame", r_tx, 48'h400000000095);
        check_val("cmd0_status", r_st, 5'b00001);

        // CMD17 good, bad CRC, wrong echoed index, bad end bit
        for (int k = 0; k < 4; k++) begin
            set_defaults(); t_idx = 6'd17; t_arg = 32'h00001000; t_type = 2'b10;
            t_ichk = 1'b1; t_cchk = 1'b1; t_n = 5; t_status = 32'h00000900;
            t_corrupt = k; t_irst_cyc = 0;
            run_cmd();
            if (k == 0) check_val("cmd17_resp0", response_0_o, 32'h00000900);
            if (k == 1) check_val("cmd17_crc_status", r_st, 5'b01011);
            if (k == 2) check_val("cmd17_idx_status", r_st, 5'b10011);
        end

        // CMD13 timeout, then sticky status across a clean command
        set_defaults(); t_idx = 6'd13; t_arg = 32'h00010000; t_irst_cyc = 0;
        run_cmd();
        check_val("cmd13_timeout_status", r_st, 5'b00111);
        set_defaults(); t_idx = 6'd13; t_n = 0; t_status = 32'h12345678;
        run_cmd();

        // Status clear coinciding with DONE keeps only the new status
        set_defaults(); t_idx = 6'd7; t_n = 2; t_status = 32'hCAFEF00D;
        t_irst_cyc = 1 + 48 + 2 + 2 + 48;
        run_cmd();
        check_val("irst_at_done_status", r_st, 5'b00001);

        // Start bit on the last WAIT cycle
        set_defaults(); t_idx = 6'd9; t_type = 2'b11; t_n = 63; t_status = 32'hA5A50F0F;
        t_cchk = 1'b1; t_irst_cyc = 0;
        run_cmd();

        // CMD2 long response
        set_defaults(); t_idx = 6'd2; t_type = 2'b01; t_n = 3; t_irst_cyc = 0;
        t_long = 128'h11223344_55667788_99AABBCC_DDEEFF01;
        run_cmd();

        // Software reset mid-TX
        set_defaults(); t_idx = 6'd17; t_arg = 32'h1; t_n = 1; t_srst_cyc = 20;
        run_cmd();

        // Second start during RX with a different command word is ignored
        set_defaults(); t_idx = 6'd17; t_arg = 32'h00002000; t_ichk = 1'b1; t_cchk = 1'b1;
        t_n = 4; t_status = 32'h00000900; t_start2_cyc = 51 + 4 + 10; t_irst_cyc = 0;
        run_cmd();

        // Hard reset mid-RX
        set_defaults(); t_idx = 6'd8; t_n = 0; t_status = 32'hFFFF0000; t_rst_cyc = 51 + 20;
        run_cmd();

        repeat (24) begin
            set_defaults();
            t_idx    = 6'($urandom_range(0, 63));
            t_arg    = $urandom;
            t_status = $urandom;
            t_long   = {$urandom, $urandom, $urandom, $urandom};
            sel      = $urandom_range(0, 3);
            t_type   = 2'(sel);
            t_ichk   = (t_type == 2'b01) ? 1'b0 : 1'($urandom_range(0, 1));
            t_cchk   = 1'($urandom_range(0, 1));
            t_n      = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 63));
            t_corrupt = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            t_irst_cyc = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 49)) : -1;
            run_cmd();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
